// File: rtl/fp_alu_pkg.sv
// Shared definitions for the FP multiplier operand sequencer: FSM encoding
// and operand byte-count constants.
package fp_alu_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EVAL   = 2'd2,
    HOLD   = 2'd3
  } seq_state_e;

  localparam int         BYTES_PER_OPERAND = 4;
  localparam logic [1:0] LAST_BYTE_IDX     = 2'(BYTES_PER_OPERAND - 1);

endpackage

// File: rtl/fp_mul_operand_seq_sticky.sv
// Accumulating exception/overflow/underflow flags. A flag captured in the
// same cycle as a clear wins over the clear.
module fp_mul_operand_seq_sticky (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       set_en_i,
  input  logic [2:0] flags_i,
  output logic [2:0] sticky_o
);

  logic [2:0] sticky_q;
  logic [2:0] sticky_d;

  always_comb begin
    sticky_d = clr_i ? 3'b000 : sticky_q;
    if (set_en_i) sticky_d = sticky_d | flags_i;
  end

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 3'b000;
    else     sticky_q <= sticky_d;
  end

  assign sticky_o = sticky_q;

endmodule

// File: rtl/fp_mul_operand_seq.sv
// Assembles two 32-bit operands from a byte stream (A then B, MSB first),
// registers the external multiplier's product and flags, and holds them for a
// valid/ready handshake downstream.
module fp_mul_operand_seq
  import fp_alu_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [31:0]        a_operand,
  output logic [31:0]        b_operand,
  input  logic [31:0]        mul_result,
  input  logic               mul_exception,
  input  logic               mul_overflow,
  input  logic               mul_underflow,
  output logic [31:0]        out_result,
  output logic               out_exception,
  output logic               out_overflow,
  output logic               out_underflow,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sticky_exception,
  output logic               sticky_overflow,
  output logic               sticky_underflow,
  input  logic               clr_sticky,
  output logic [COUNT_W-1:0] op_count,
  output logic [1:0]         dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and data/valid stay put until taken.
  seq_state_e         state_q;
  logic [1:0]         byte_idx_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [31:0]        res_q;
  logic [2:0]         flags_q;
  logic               out_valid_q;
  logic               in_ready_q;
  logic [COUNT_W-1:0] op_count_q;
  logic [2:0]         sticky;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD_A;
      byte_idx_q  <= 2'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      res_q       <= 32'd0;
      flags_q     <= 3'b000;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (in_valid) begin
            a_q        <= {a_q[23:0], in_data};
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == LAST_BYTE_IDX) state_q <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (in_valid) begin
            b_q        <= {b_q[23:0], in_data};
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == LAST_BYTE_IDX) begin
              state_q    <= EVAL;
              in_ready_q <= 1'b0;
            end
          end
        end
        EVAL: begin
          // Operands have been stable for a full cycle; the product is settled.
          res_q       <= mul_result;
          flags_q     <= {mul_exception, mul_overflow, mul_underflow};
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            op_count_q  <= op_count_q + COUNT_W'(1);
            state_q     <= LOAD_A;
          end
        end
        default: state_q <= LOAD_A;
      endcase
    end
  end

  fp_mul_operand_seq_sticky u_sticky (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr_sticky),
    .set_en_i (state_q == EVAL),
    .flags_i  ({mul_exception, mul_overflow, mul_underflow}),
    .sticky_o (sticky)
  );

  assign in_ready         = in_ready_q;
  assign a_operand        = a_q;
  assign b_operand        = b_q;
  assign out_result       = res_q;
  assign out_exception    = flags_q[2];
  assign out_overflow     = flags_q[1];
  assign out_underflow    = flags_q[0];
  assign out_valid        = out_valid_q;
  assign sticky_exception = sticky[2];
  assign sticky_overflow  = sticky[1];
  assign sticky_underflow = sticky[0];
  assign op_count         = op_count_q;
  assign dbg_state_o      = state_q;

endmodule
